// File: rtl/b_row_feeder_if.sv
// Loader/controller-facing bundle of b_row_feeder: row writes, start/hold control,
// status flags and the row stream toward the memB skew buffer.
interface b_row_feeder_if #(
    parameter int BITS_AB = 8,
    parameter int DIM     = 8
);
    logic                      wr_en;
    logic signed [BITS_AB-1:0] wr_row [DIM-1:0];
    logic                      start;
    logic                      hold;
    logic                      full;
    logic                      busy;
    logic                      done;
    logic                      en_out;
    logic signed [BITS_AB-1:0] Bout [DIM-1:0];

    modport master (
        output wr_en, wr_row, start, hold,
        input  full, busy, done, en_out, Bout
    );

    modport slave (
        input  wr_en, wr_row, start, hold,
        output full, busy, done, en_out, Bout
    );
endinterface

// File: rtl/b_row_feeder.sv
// Buffers DIM rows of B, streams them one per cycle into the memB skew buffer, then
// 2*DIM-1 zero rows to drain it. Define B_FEED_TRANSPOSE_EN to stream columns instead.
module b_row_feeder #(
    parameter int BITS_AB = 8,
    parameter int DIM     = 8
) (
    input logic           clk,
    input logic           rst,
    b_row_feeder_if.slave bus
);
    localparam int AW = $clog2(DIM);
    localparam int CW = $clog2(DIM) + 1;
    localparam int FW = $clog2(2 * DIM) + 1;
    localparam logic [CW-1:0] ROWS_FULL  = CW'(DIM);
    localparam logic [CW-1:0] ROW_LAST   = CW'(DIM - 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(2 * DIM - 1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FLUSH,
        DONE
    } state_t;

    state_t                    state;
    state_t                    state_next;
    logic [CW-1:0]             count;
    logic [CW-1:0]             count_next;
    logic [CW-1:0]             row_idx;
    logic [CW-1:0]             row_idx_next;
    logic [FW-1:0]             flush_cnt;
    logic [FW-1:0]             flush_cnt_next;
    logic                      full_q;
    logic                      full_next;
    logic                      busy_q;
    logic                      busy_next;
    logic                      done_q;
    logic                      done_next;
    logic                      en_q;
    logic                      en_next;
    logic                      buf_we;
    logic [AW-1:0]             step_sel;
    logic signed [BITS_AB-1:0] bout_q    [DIM-1:0];
    logic signed [BITS_AB-1:0] bout_next [DIM-1:0];
    logic signed [BITS_AB-1:0] step_vec  [DIM-1:0];
    logic signed [BITS_AB-1:0] row_buf   [DIM-1:0][DIM-1:0];

    // Matrix storage needs no reset: a cleared row count makes old contents unreachable.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            row_buf[count[AW-1:0]] <= bus.wr_row;
        end
    end

    // Index of the row (or column) that goes out on the next advancing edge.
    always_comb begin
        step_sel = '0;
        if (state == STREAM) begin
            step_sel = row_idx[AW-1:0] + AW'(1);
        end
    end

    for (genvar g = 0; g < DIM; g++) begin : g_lane
`ifdef B_FEED_TRANSPOSE_EN
        assign step_vec[g] = row_buf[g][step_sel];
`else
        assign step_vec[g] = row_buf[step_sel][g];
`endif
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_next     = state;
        count_next     = count;
        row_idx_next   = row_idx;
        flush_cnt_next = flush_cnt;
        full_next      = full_q;
        busy_next      = busy_q;
        done_next      = 1'b0;
        en_next        = en_q;
        bout_next      = bout_q;
        buf_we         = 1'b0;

        unique case (state)
            IDLE: begin
                busy_next = 1'b0;
                en_next   = 1'b0;
                if (bus.start && full_q) begin
                    state_next   = STREAM;
                    row_idx_next = '0;
                    busy_next    = 1'b1;
                    en_next      = 1'b1;
                    bout_next    = step_vec;
                end else if (bus.wr_en && (count != ROWS_FULL)) begin
                    buf_we     = 1'b1;
                    count_next = count + CW'(1);
                    full_next  = ((count + CW'(1)) == ROWS_FULL);
                end
            end

            STREAM: begin
                if (bus.hold) begin
                    en_next = 1'b0;
                end else if (row_idx == ROW_LAST) begin
                    state_next     = FLUSH;
                    flush_cnt_next = FW'(1);
                    en_next        = 1'b1;
                    bout_next      = '{default: '0};
                end else begin
                    row_idx_next = row_idx + CW'(1);
                    en_next      = 1'b1;
                    bout_next    = step_vec;
                end
            end

            FLUSH: begin
                if (bus.hold) begin
                    en_next = 1'b0;
                end else if (flush_cnt == FLUSH_LAST) begin
                    state_next = DONE;
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                    en_next    = 1'b0;
                    bout_next  = '{default: '0};
                    count_next = '0;
                    full_next  = 1'b0;
                end else begin
                    flush_cnt_next = flush_cnt + FW'(1);
                    en_next        = 1'b1;
                end
            end

            DONE: begin
                state_next = IDLE;
                busy_next  = 1'b0;
                en_next    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            row_idx   <= '0;
            flush_cnt <= '0;
            full_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            en_q      <= 1'b0;
            bout_q    <= '{default: '0};
        end else begin
            state     <= state_next;
            count     <= count_next;
            row_idx   <= row_idx_next;
            flush_cnt <= flush_cnt_next;
            full_q    <= full_next;
            busy_q    <= busy_next;
            done_q    <= done_next;
            en_q      <= en_next;
            bout_q    <= bout_next;
        end
    end

    assign bus.full   = full_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.en_out = en_q;
    assign bus.Bout   = bout_q;
endmodule

// File: tb/tb_b_row_feeder.sv
// Directed bench for b_row_feeder (DIM=8): load, stream, flush, hold, ignored
// writes/starts and asynchronous reset; follows B_FEED_TRANSPOSE_EN if defined.
module tb_b_row_feeder;
    localparam int BITS_AB = 8;
    localparam int DIM     = 8;
    localparam int STEPS   = 3 * DIM - 1;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    logic signed [BITS_AB-1:0] mdl [DIM][DIM];

    b_row_feeder_if #(.BITS_AB(BITS_AB), .DIM(DIM)) bus ();

    b_row_feeder #(.BITS_AB(BITS_AB), .DIM(DIM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected lane i at stream step k: data steps first, then zero flush rows.
    function automatic logic signed [BITS_AB-1:0] exp_lane(input int k, input int i);
        if (k >= DIM) return '0;
`ifdef B_FEED_TRANSPOSE_EN
        return mdl[i][k];
`else
        return mdl[k][i];
`endif
    endfunction

    task automatic write_rows(input int first, input int n, input int base);
        for (int r = first; r < first + n; r++) begin
            bus.wr_en = 1'b1;
            for (int i = 0; i < DIM; i++) begin
                int v;
                v = base + 8 * r + i;
                bus.wr_row[i] = BITS_AB'(v);
                mdl[r][i]     = BITS_AB'(v);
            end
            tick();
        end
        bus.wr_en = 1'b0;
    endtask

    task automatic stream_and_check(input int hold_at, input int hold_len, input string name);
        int bad_lane;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int s = 0; s < STEPS; s++) begin
            checks++;
            if (bus.en_out !== 1'b1 || bus.busy !== 1'b1) begin
                failures++;
                $display("[TB] FAIL %s step %0d en_out/busy got %b/%b want 1/1", name, s, bus.en_out, bus.busy);
            end
            bad_lane = -1;
            for (int i = 0; i < DIM; i++) if (bus.Bout[i] !== exp_lane(s, i)) bad_lane = i;
            checks++;
            if (bad_lane >= 0) begin
                failures++;
                $display("[TB] FAIL %s step %0d Bout[%0d] got %0d want %0d", name, s, bad_lane,
                         bus.Bout[bad_lane], exp_lane(s, bad_lane));
            end
            if (s == hold_at) begin
                bus.hold = 1'b1;
                for (int h = 0; h < hold_len; h++) begin
                    tick();
                    checks++;
                    if (bus.en_out !== 1'b0 || bus.busy !== 1'b1) begin
                        failures++;
                        $display("[TB] FAIL %s hold %0d en_out/busy got %b/%b want 0/1", name, h, bus.en_out, bus.busy);
                    end
                    bad_lane = -1;
                    for (int i = 0; i < DIM; i++) if (bus.Bout[i] !== exp_lane(s, i)) bad_lane = i;
                    checks++;
                    if (bad_lane >= 0) begin
                        failures++;
                        $display("[TB] FAIL %s hold %0d Bout[%0d] got %0d want %0d", name, h, bad_lane,
                                 bus.Bout[bad_lane], exp_lane(s, bad_lane));
                    end
                end
                bus.hold = 1'b0;
            end
            tick();
        end
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.en_out !== 1'b0 || bus.full !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s done cycle done/busy/en_out/full got %b/%b/%b/%b want 1/0/0/0",
                     name, bus.done, bus.busy, bus.en_out, bus.full);
        end
        bad_lane = -1;
        for (int i = 0; i < DIM; i++) if (bus.Bout[i] !== '0) bad_lane = i;
        checks++;
        if (bad_lane >= 0) begin
            failures++;
            $display("[TB] FAIL %s done cycle Bout[%0d] got %0d want 0", name, bad_lane, bus.Bout[bad_lane]);
        end
        tick();
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s after done done/busy got %b/%b want 0/0", name, bus.done, bus.busy);
        end
    endtask

    task automatic test_reset();
        int bad_lane;
        bus.wr_en = 1'b0;
        bus.start = 1'b0;
        bus.hold  = 1'b0;
        for (int i = 0; i < DIM; i++) bus.wr_row[i] = '0;
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.full !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.en_out !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset flags full/busy/done/en_out got %b/%b/%b/%b want 0/0/0/0",
                     bus.full, bus.busy, bus.done, bus.en_out);
        end
        bad_lane = -1;
        for (int i = 0; i < DIM; i++) if (bus.Bout[i] !== '0) bad_lane = i;
        checks++;
        if (bad_lane >= 0) begin
            failures++;
            $display("[TB] FAIL reset Bout[%0d] got %0d want 0", bad_lane, bus.Bout[bad_lane]);
        end
        rst = 1'b0;
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.en_out !== 1'b0) begin
            failures++;
            $display("[TB] FAIL empty_start busy/en_out got %b/%b want 0/0", bus.busy, bus.en_out);
        end
    endtask

    task automatic test_stream();
        write_rows(0, 7, 0);
        checks++;
        if (bus.full !== 1'b0) begin
            failures++;
            $display("[TB] FAIL stream 7 rows full got %b want 0", bus.full);
        end
        write_rows(7, 1, 0);
        checks++;
        if (bus.full !== 1'b1) begin
            failures++;
            $display("[TB] FAIL stream 8 rows full got %b want 1", bus.full);
        end
        stream_and_check(-1, 0, "stream");
    endtask

    task automatic test_overflow_write();
        write_rows(0, 8, 16);
        bus.wr_en = 1'b1;
        for (int i = 0; i < DIM; i++) bus.wr_row[i] = 8'sh7F;
        tick();
        bus.wr_en = 1'b0;
        checks++;
        if (bus.full !== 1'b1 || bus.busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL overflow full/busy got %b/%b want 1/0", bus.full, bus.busy);
        end
        stream_and_check(-1, 0, "overflow");
    endtask

    task automatic test_early_start();
        write_rows(0, 5, -128);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.full !== 1'b0) begin
            failures++;
            $display("[TB] FAIL early_start busy/full got %b/%b want 0/0", bus.busy, bus.full);
        end
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.en_out !== 1'b0) begin
            failures++;
            $display("[TB] FAIL early_start later busy/en_out got %b/%b want 0/0", bus.busy, bus.en_out);
        end
        write_rows(5, 2, -128);
        checks++;
        if (bus.full !== 1'b0) begin
            failures++;
            $display("[TB] FAIL early_start 7 rows full got %b want 0", bus.full);
        end
        bus.start = 1'b1;
        write_rows(7, 1, -128);
        bus.start = 1'b0;
        checks++;
        if (bus.full !== 1'b1 || bus.busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL start_with_last_write full/busy got %b/%b want 1/0", bus.full, bus.busy);
        end
        tick();
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL start_with_last_write later busy got %b want 0", bus.busy);
        end
        stream_and_check(-1, 0, "early_start");
    endtask

    task automatic test_hold();
        write_rows(0, 8, 64);
        stream_and_check(3, 3, "hold");
    endtask

    task automatic test_reset_midflush();
        int bad_lane;
        write_rows(0, 8, -64);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int s = 0; s < DIM + 4; s++) tick();
        checks++;
        if (bus.en_out !== 1'b1 || bus.busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL midflush pre-reset en_out/busy got %b/%b want 1/1", bus.en_out, bus.busy);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.en_out !== 1'b0 || bus.full !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midflush reset busy/en_out/full/done got %b/%b/%b/%b want 0/0/0/0",
                     bus.busy, bus.en_out, bus.full, bus.done);
        end
        bad_lane = -1;
        for (int i = 0; i < DIM; i++) if (bus.Bout[i] !== '0) bad_lane = i;
        checks++;
        if (bad_lane >= 0) begin
            failures++;
            $display("[TB] FAIL midflush reset Bout[%0d] got %0d want 0", bad_lane, bus.Bout[bad_lane]);
        end
        #1;
        rst = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.en_out !== 1'b0) begin
            failures++;
            $display("[TB] FAIL post_reset start busy/en_out got %b/%b want 0/0", bus.busy, bus.en_out);
        end
        write_rows(0, 7, 3);
        checks++;
        if (bus.full !== 1'b0) begin
            failures++;
            $display("[TB] FAIL post_reset 7 rows full got %b want 0", bus.full);
        end
        write_rows(7, 1, 3);
        stream_and_check(-1, 0, "post_reset");
    endtask

    initial begin
        test_reset();
        test_stream();
        test_overflow_write();
        test_early_start();
        test_hold();
        test_reset_midflush();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
